// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the ysyx_23060187 decode stage: opcodes, instruction
// format codes, buffer states and the decoded-instruction bundle.
// Optional feature macro: YSYX_23060187_ILLEGAL_CHK_EN (illegal-instruction flag).
package ysyx_23060187_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // The only SYSTEM encodings accepted when illegal checking is enabled
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Storage width of pc/imm inside the bundle; the top slices down to XLEN
    localparam int XLEN_MAX = 64;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [6:0]          opcode;
        logic [2:0]          fun3;
        logic                fun7;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic                rs1_en;
        logic                rs2_en;
        logic                rd_we;
        fmt_e                fmt;
        logic [XLEN_MAX-1:0] imm;
        logic                illegal;
    } dec_bundle_t;

    // Opcode to instruction format; the *-32 opcodes only exist on RV64
    function automatic fmt_e opcode_fmt(input logic [6:0] opc, input logic rv64);
        fmt_e f;
        case (opc)
            OPC_LUI, OPC_AUIPC:                      f = FMT_U;
            OPC_JAL:                                 f = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_SYSTEM:                              f = FMT_I;
            OPC_STORE:                               f = FMT_S;
            OPC_BRANCH:                              f = FMT_B;
            OPC_OP:                                  f = FMT_R;
            OPC_OP_IMM_32:                           f = rv64 ? FMT_I : FMT_NONE;
            OPC_OP_32:                               f = rv64 ? FMT_R : FMT_NONE;
            default:                                 f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ysyx_23060187_imm_gen.sv
// Immediate generator: assembles the immediate for each RV32I/RV64I format
// and sign-extends it from inst[31] to XLEN. R-type and unknown formats yield 0.
module ysyx_23060187_imm_gen
    import ysyx_23060187_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  fmt_e            fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;
    logic        unused_opc;

    // The opcode field never contributes to an immediate
    assign unused_opc = ^inst_i[6:0];

    // Per-format bit gather into a 32-bit signed immediate
    always_comb begin
        imm32 = '0;
        case (fmt_i)
            FMT_I:   imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            FMT_S:   imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            FMT_B:   imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                              inst_i[30:25], inst_i[11:8], 1'b0};
            FMT_U:   imm32 = {inst_i[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                              inst_i[20], inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Widen to XLEN keeping the sign
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/ysyx_23060187_decode_stage.sv
// Decode stage between fetch and execute. Decodes the incoming instruction
// combinationally and holds results in a two-entry skid buffer (main + skid)
// so in_ready can be a register while still sustaining one instruction/cycle.
// Optional feature macro: YSYX_23060187_ILLEGAL_CHK_EN adds out_illegal.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_EMPTY | nothing buffered, in_ready = 1
// ST_BUSY  | main holds one entry presented on the outputs, in_ready = 1
// ST_FULL  | main and skid both hold entries, in_ready = 0
module ysyx_23060187_decode_stage
    import ysyx_23060187_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_fun3,
    output logic            out_fun7,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic            out_rd_we,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
    ,
    output logic            out_illegal
`endif
);

    buf_state_e       state_q, state_d;
    logic             in_ready_q;
    dec_bundle_t      dec;
    dec_bundle_t      main_q, main_d;
    dec_bundle_t      skid_q, skid_d;
    fmt_e             fmt;
    logic [XLEN-1:0]  imm_x;
    logic             accept;
    logic             drain;
    logic             unused_bits;

    // Upper pc/imm bits and (without the checker) the illegal bit are never read
    assign unused_bits = ^{main_q, skid_q};

    assign fmt = opcode_fmt(in_inst[6:0], XLEN == 64);

    ysyx_23060187_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .inst_i (in_inst),
        .fmt_i  (fmt),
        .imm_o  (imm_x)
    );

    // Combinational decode of the offered instruction into a bundle
    always_comb begin
        dec        = '0;
        dec.pc     = XLEN_MAX'(in_pc);
        dec.opcode = in_inst[6:0];
        dec.fun3   = in_inst[14:12];
        dec.fun7   = in_inst[30];
        dec.rs1    = in_inst[19:15];
        dec.rs2    = in_inst[24:20];
        dec.rd     = in_inst[11:7];
        dec.fmt    = fmt;
        dec.rs1_en = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        dec.rs2_en = fmt inside {FMT_R, FMT_S, FMT_B};
        dec.rd_we  = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (in_inst[11:7] != 5'd0);
        dec.imm    = XLEN_MAX'($signed(imm_x));
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
        dec.illegal = (fmt == FMT_NONE) ||
                      ((in_inst[6:0] == OPC_SYSTEM) &&
                       (in_inst != INST_ECALL) && (in_inst != INST_EBREAK));
`endif
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid & out_ready;

    // Next-state and entry movement; flush overrides any accept or drain
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_BUSY;
                        main_d  = dec;
                    end
                end
                ST_BUSY: begin
                    if (accept && !drain) begin
                        state_d = ST_FULL;
                        skid_d  = dec;
                    end else if (accept && drain) begin
                        main_d  = dec;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State register; in_ready is precomputed from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Buffer entries, cleared on reset so the outputs read back as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    // Outputs always come from the main entry
    always_comb begin
        in_ready   = in_ready_q;
        out_valid  = (state_q == ST_BUSY) || (state_q == ST_FULL);
        out_pc     = main_q.pc[XLEN-1:0];
        out_opcode = main_q.opcode;
        out_fun3   = main_q.fun3;
        out_fun7   = main_q.fun7;
        out_rs1    = main_q.rs1;
        out_rs2    = main_q.rs2;
        out_rd     = main_q.rd;
        out_rs1_en = main_q.rs1_en;
        out_rs2_en = main_q.rs2_en;
        out_rd_we  = main_q.rd_we;
        out_fmt    = main_q.fmt;
        out_imm    = main_q.imm[XLEN-1:0];
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
        out_illegal = main_q.illegal;
`endif
    end

endmodule

// File: tb/tb_ysyx_23060187_decode_stage.sv
// Directed bench for the decode stage: an XLEN=32 and an XLEN=64 instance
// share the same stimulus.
// Optional feature macro: YSYX_23060187_ILLEGAL_CHK_EN.
module tb_ysyx_23060187_decode_stage;
    import ysyx_23060187_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;
    logic [63:0] in_pc64;

    logic        ir32, ov32, f7_32, rs1en32, rs2en32, rdwe32;
    logic [31:0] pc32, imm32;
    logic [6:0]  opc32;
    logic [2:0]  f3_32, fmt32;
    logic [4:0]  rs1_32, rs2_32, rd32;

    logic        ir64, ov64, f7_64, rs1en64, rs2en64, rdwe64;
    logic [63:0] pc64, imm64;
    logic [6:0]  opc64;
    logic [2:0]  f3_64, fmt64;
    logic [4:0]  rs1_64, rs2_64, rd64;
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
    logic        ill32, ill64;
`endif

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;
    assign in_pc64 = {32'h0, in_pc};

    ysyx_23060187_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov32), .out_ready(out_ready),
        .out_pc(pc32), .out_opcode(opc32), .out_fun3(f3_32), .out_fun7(f7_32),
        .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd32), .out_rs1_en(rs1en32),
        .out_rs2_en(rs2en32), .out_rd_we(rdwe32), .out_fmt(fmt32), .out_imm(imm32)
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
        , .out_illegal(ill32)
`endif
    );

    ysyx_23060187_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
        .in_inst(in_inst), .in_pc(in_pc64), .out_valid(ov64), .out_ready(out_ready),
        .out_pc(pc64), .out_opcode(opc64), .out_fun3(f3_64), .out_fun7(f7_64),
        .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd64), .out_rs1_en(rs1en64),
        .out_rs2_en(rs2en64), .out_rd_we(rdwe64), .out_fmt(fmt64), .out_imm(imm64)
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
        , .out_illegal(ill64)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    // Checks the XLEN=32 instance's presented entry
    task automatic check_dec(input string tag, input logic [2:0] f, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic e1,
                             input logic e2, input logic we, input logic [31:0] imm,
                             input logic [31:0] pc);
        chk({tag, ".valid"},  ov32,    1);
        chk({tag, ".ready"},  ir32,    1);
        chk({tag, ".pc"},     pc32,    pc);
        chk({tag, ".fmt"},    fmt32,   f);
        chk({tag, ".rs1"},    rs1_32,  rs1);
        chk({tag, ".rs2"},    rs2_32,  rs2);
        chk({tag, ".rd"},     rd32,    rd);
        chk({tag, ".rs1_en"}, rs1en32, e1);
        chk({tag, ".rs2_en"}, rs2en32, e2);
        chk({tag, ".rd_we"},  rdwe32,  we);
        chk({tag, ".imm"},    imm32,   imm);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_inst   = '0;
        in_pc     = '0;

        // Reset values
        #12;
        chk("rst.valid", ov32, 0);
        chk("rst.ready", ir32, 1);
        chk("rst.pc",    pc32, 0);
        chk("rst.imm",   imm32, 0);
        chk("rst.fmt",   fmt32, 0);
        chk("rst.rd_we", rdwe32, 0);
        chk("rst.imm64", imm64, 0);
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
        chk("rst.illegal", ill32, 0);
`endif
        rst_n = 1'b1;

        // Back-to-back stream with out_ready held high
        offer(32'hFFF0_0093, 32'h100); step();   // addi x1,x0,-1
        check_dec("addi", FMT_I, 0, 31, 1, 1, 0, 1, 32'hFFFF_FFFF, 32'h100);
        chk("addi.imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi.fun3", f3_32, 0);

        offer(32'h0020_A423, 32'h104); step();   // sw x2,8(x1)
        check_dec("sw", FMT_S, 1, 2, 8, 1, 1, 0, 32'h8, 32'h104);
        chk("sw.fun3", f3_32, 2);

        offer(32'hFE00_0EE3, 32'h108); step();   // beq x0,x0,-4
        check_dec("beq", FMT_B, 0, 0, 29, 1, 1, 0, 32'hFFFF_FFFC, 32'h108);

        offer(32'h8000_02B7, 32'h10C); step();   // lui x5,0x80000
        check_dec("lui", FMT_U, 0, 0, 5, 0, 0, 1, 32'h8000_0000, 32'h10C);
        chk("lui.imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        chk("lui.rd64",  rd64, 5);
        chk("lui.pc64",  pc64, 64'h10C);

        offer(32'hFF9F_F0EF, 32'h110); step();   // jal x1,-8
        check_dec("jal", FMT_J, 31, 25, 1, 0, 0, 1, 32'hFFFF_FFF8, 32'h110);
        chk("jal.imm64", imm64, 64'hFFFF_FFFF_FFFF_FFF8);

        offer(32'h4020_81B3, 32'h114); step();   // sub x3,x1,x2
        check_dec("sub", FMT_R, 1, 2, 3, 1, 1, 1, 32'h0, 32'h114);
        chk("sub.fun7",   f7_32, 1);
        chk("sub.opcode", opc32, 7'h33);

        offer(32'h0000_0013, 32'h118); step();   // addi x0,x0,0 (rd = 0)
        check_dec("nop", FMT_I, 0, 0, 0, 1, 0, 0, 32'h0, 32'h118);

        offer(32'h0020_81BB, 32'h11C); step();   // addw: RV64 only
        chk("addw.fmt32",   fmt32, FMT_NONE);
        chk("addw.rd_we32", rdwe32, 0);
        chk("addw.rs1en32", rs1en32, 0);
        chk("addw.fmt64",   fmt64, FMT_R);
        chk("addw.rd_we64", rdwe64, 1);
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
        chk("addw.ill32", ill32, 1);
        chk("addw.ill64", ill64, 0);
`endif

        offer(32'h0000_0073, 32'h120); step();   // ecall
        chk("ecall.fmt", fmt32, FMT_I);
        chk("ecall.pc",  pc32, 32'h120);
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
        chk("ecall.ill", ill32, 0);
`endif

        offer(32'h0000_00FF, 32'h124); step();   // unknown opcode, rd field = 1
        chk("bad.fmt",   fmt32, FMT_NONE);
        chk("bad.rd_we", rdwe32, 0);
        chk("bad.rs2en", rs2en32, 0);
        chk("bad.imm",   imm32, 0);
        chk("bad.valid", ov32, 1);
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
        chk("bad.ill", ill32, 1);
`endif

        offer(32'h0000_007F, 32'h128); step();
        chk("7f.fmt", fmt32, FMT_NONE);
        chk("7f.imm", imm32, 0);
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
        chk("7f.ill", ill32, 1);
`endif

        offer(32'h0020_0073, 32'h12C); step();   // SYSTEM, not ecall/ebreak
        chk("sys.fmt", fmt32, FMT_I);
        chk("sys.pc",  pc32, 32'h12C);
`ifdef YSYX_23060187_ILLEGAL_CHK_EN
        chk("sys.ill", ill32, 1);
`endif

        in_valid = 1'b0; step();
        chk("drain.valid", ov32, 0);
        chk("drain.ready", ir32, 1);

        // Back-pressure: out_ready low for 3 cycles starting with the second instruction
        offer(32'h0000_0013, 32'h200); step();
        chk("bp.a.pc", pc32, 32'h200);
        offer(32'h0000_0013, 32'h204); out_ready = 1'b0; step();
        chk("bp.full.ready", ir32, 0);
        chk("bp.full.pc",    pc32, 32'h200);
        offer(32'h0000_0013, 32'h208); step();
        chk("bp.hold1.pc",    pc32, 32'h200);
        chk("bp.hold1.valid", ov32, 1);
        chk("bp.hold1.ready", ir32, 0);
        step();
        chk("bp.hold2.pc",  pc32, 32'h200);
        chk("bp.hold2.fmt", fmt32, FMT_I);
        out_ready = 1'b1; step();
        chk("bp.b.pc",    pc32, 32'h204);
        chk("bp.b.ready", ir32, 1);
        step();
        chk("bp.c.pc", pc32, 32'h208);
        offer(32'h0000_0013, 32'h20C); step();
        chk("bp.d.pc", pc32, 32'h20C);
        in_valid = 1'b0; step();
        chk("bp.end.valid", ov32, 0);

        // Flush while FULL, with a same-cycle offer
        out_ready = 1'b0;
        offer(32'h0000_0013, 32'h300); step();
        offer(32'h0000_0013, 32'h304); step();
        chk("fl.full.ready", ir32, 0);
        flush = 1'b1;
        offer(32'h0000_0013, 32'h308); step();
        chk("fl.valid", ov32, 0);
        chk("fl.ready", ir32, 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        chk("fl.after.valid", ov32, 0);
        step();
        chk("fl.after2.valid", ov32, 0);
        offer(32'h0000_0013, 32'h30C); step();
        chk("fl.next.pc",    pc32, 32'h30C);
        chk("fl.next.valid", ov32, 1);
        in_valid = 1'b0; step();
        chk("fl.end.valid", ov32, 0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        offer(32'h0000_0013, 32'h400); step();
        offer(32'h0000_0013, 32'h404); step();
        chk("ar.pre.valid", ov32, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.valid", ov32, 0);
        chk("ar.ready", ir32, 1);
        chk("ar.pc",    pc32, 0);
        chk("ar.valid64", ov64, 0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        offer(32'h0000_0013, 32'h408); step();
        chk("ar.next.pc",    pc32, 32'h408);
        chk("ar.next.valid", ov32, 1);
        in_valid = 1'b0; step();
        chk("ar.end.valid", ov32, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
